// File: rtl/countdown_display.sv
// Two-digit multiplexed display of a 4-bit count (00-15) with leading-zero
// blanking, 0->15 wrap detection and a blinking alarm after each wrap.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | normal display, decimal point dark, waiting for a wrap pulse
// ON    | alarm on-phase: normal display with decimal point lit
// OFF   | alarm off-phase: whole display blanked
module countdown_display #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_DIV    = 50000,
   parameter int ALARM_BLINKS = 4
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic [3:0] count,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       dp,
   output logic       wrap,
   output logic       alarm
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int NW = $clog2(ALARM_BLINKS + 1);

   localparam logic [SW-1:0] SCAN_TC     = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_TC    = BW'(BLINK_DIV - 1);
   localparam logic [NW-1:0] BLINKS_LAST = NW'(ALARM_BLINKS - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      cnt_p_q, cnt_p_d;
   logic            wrap_q, wrap_d;
   logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
   logic            digit_q, digit_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic [NW-1:0]   blinks_q, blinks_d;
   logic [6:0]      seg_q, seg_d;
   logic [1:0]      an_q, an_d;
   logic            dp_q, dp_d;
   logic            alarm_q, alarm_d;

   logic            scan_tc;
   logic            blink_tc;
   logic            tens;
   logic [3:0]      ones;

   // Both pipeline stages reset to 15 so the reset value can never look like 0->15.
   always_comb begin
      cnt_d   = count;
      cnt_p_d = cnt_q;
      wrap_d  = (cnt_p_q == 4'd0) && (cnt_q == 4'hF);
   end

   always_comb begin
      scan_tc    = (scan_cnt_q == SCAN_TC);
      scan_cnt_d = scan_tc ? '0 : scan_cnt_q + SW'(1);
      digit_d    = digit_q ^ scan_tc;
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         cnt_q      <= 4'hF;
         cnt_p_q    <= 4'hF;
         wrap_q     <= 1'b0;
         scan_cnt_q <= '0;
         digit_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         cnt_p_q    <= cnt_p_d;
         wrap_q     <= wrap_d;
         scan_cnt_q <= scan_cnt_d;
         digit_q    <= digit_d;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         blink_cnt_q <= '0;
         blinks_q    <= '0;
      end else begin
         state_q     <= state_d;
         blink_cnt_q <= blink_cnt_d;
         blinks_q    <= blinks_d;
      end
   end

   // A wrap in any state restarts the alarm, ahead of any phase change.
   always_comb begin
      state_d     = state_q;
      blink_cnt_d = blink_cnt_q;
      blinks_d    = blinks_q;
      blink_tc    = (blink_cnt_q == BLINK_TC);
      unique case (state_q)
         ST_IDLE: begin
            blink_cnt_d = '0;
            if (wrap_q) begin
               state_d  = ST_ON;
               blinks_d = '0;
            end
         end
         ST_ON: begin
            if (wrap_q) begin
               blink_cnt_d = '0;
               blinks_d    = '0;
            end else if (blink_tc) begin
               state_d     = ST_OFF;
               blink_cnt_d = '0;
            end else begin
               blink_cnt_d = blink_cnt_q + BW'(1);
            end
         end
         ST_OFF: begin
            if (wrap_q) begin
               state_d     = ST_ON;
               blink_cnt_d = '0;
               blinks_d    = '0;
            end else if (blink_tc) begin
               blink_cnt_d = '0;
               blinks_d    = blinks_q + NW'(1);
               state_d     = (blinks_q == BLINKS_LAST) ? ST_IDLE : ST_ON;
            end else begin
               blink_cnt_d = blink_cnt_q + BW'(1);
            end
         end
         default: begin
            state_d     = ST_IDLE;
            blink_cnt_d = '0;
            blinks_d    = '0;
         end
      endcase
   end

   always_comb begin
      tens    = (cnt_q >= 4'd10);
      ones    = tens ? (cnt_q - 4'd10) : cnt_q;
      seg_d   = SEG_BLANK;
      an_d    = 2'b11;
      dp_d    = 1'b1;
      alarm_d = (state_q != ST_IDLE);
      if (state_q != ST_OFF) begin
         dp_d = (state_q == ST_ON) ? 1'b0 : 1'b1;
         if (!digit_q) begin
            an_d  = 2'b10;
            seg_d = seg_code(ones);
         end else if (tens) begin
            an_d  = 2'b01;
            seg_d = seg_code(4'd1);
         end
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         seg_q   <= SEG_BLANK;
         an_q    <= 2'b11;
         dp_q    <= 1'b1;
         alarm_q <= 1'b0;
      end else begin
         seg_q   <= seg_d;
         an_q    <= an_d;
         dp_q    <= dp_d;
         alarm_q <= alarm_d;
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign dp    = dp_q;
   assign wrap  = wrap_q;
   assign alarm = alarm_q;

endmodule

// File: tb/tb_countdown_display.sv
// Bench for countdown_display: decode table, hand-built wrap/alarm/reset
// sequences and a randomized run against a closed-form reference model.
module tb_countdown_display;

   localparam int SCAN_DIV     = 4;
   localparam int BLINK_DIV    = 8;
   localparam int ALARM_BLINKS = 2;
   localparam int ALARM_LEN    = 2 * BLINK_DIV * ALARM_BLINKS;
   localparam int MAXT         = 2048;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] count = 4'd0;
   logic [6:0] seg;
   logic [1:0] an;
   logic       dp;
   logic       wrap;
   logic       alarm;

   always #5 clk = ~clk;

   countdown_display #(
      .SCAN_DIV    (SCAN_DIV),
      .BLINK_DIV   (BLINK_DIV),
      .ALARM_BLINKS(ALARM_BLINKS)
   ) dut (
      .clk  (clk),
      .Reset(rst),
      .count(count),
      .seg  (seg),
      .an   (an),
      .dp   (dp),
      .wrap (wrap),
      .alarm(alarm)
   );

   typedef struct {
      logic [3:0] cnt;
      logic [6:0] ones_seg;
      logic [1:0] tens_an;
      logic [6:0] tens_seg;
   } vec_t;

   vec_t       tbl[16];
   int         n_vec = 0;
   int         n_err = 0;
   int         t = 0;
   logic [3:0] hist[MAXT];
   bit         wrap_flag[MAXT];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
      end
   endtask

   // Count value held in the first pipeline stage after s edges since reset.
   function automatic logic [3:0] cq(input int s);
      if (s <= 0) return 4'hF;
      return hist[s];
   endfunction

   function automatic logic [6:0] code(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // Alarm phase after s edges: 0 idle, 1 on, 2 off, from the latest wrap pulse.
   function automatic int st_at(input int s);
      int lo;
      lo = s - 1 - ALARM_LEN;
      if (lo < 1) lo = 1;
      for (int w = s - 1; w >= lo; w--) begin
         if (wrap_flag[w]) begin
            int e;
            e = s - (w + 1);
            if (e >= ALARM_LEN) return 0;
            return ((e / BLINK_DIV) % 2 != 0) ? 2 : 1;
         end
      end
      return 0;
   endfunction

   task automatic check_model();
      int         st;
      int         dig;
      int         v;
      logic [6:0] es;
      logic [1:0] ea;
      st  = st_at(t - 1);
      dig = ((t - 1) / SCAN_DIV) % 2;
      v   = int'(cq(t - 1));
      if (st == 2) begin
         ea = 2'b11; es = 7'h7F;
      end else if (dig == 0) begin
         ea = 2'b10; es = code(v % 10);
      end else if (v >= 10) begin
         ea = 2'b01; es = code(1);
      end else begin
         ea = 2'b11; es = 7'h7F;
      end
      chk("seg", seg, es);
      chk("an", an, ea);
      chk("dp", dp, (st == 1) ? 1'b0 : 1'b1);
      chk("wrap", wrap, wrap_flag[t]);
      chk("alarm", alarm, (st != 0) ? 1'b1 : 1'b0);
   endtask

   // Called at a falling edge; applies c, crosses one rising edge, checks, returns at next falling edge.
   task automatic step(input logic [3:0] c);
      count = c;
      @(posedge clk);
      t++;
      hist[t]      = c;
      wrap_flag[t] = (cq(t - 2) == 4'd0) && (cq(t - 1) == 4'hF);
      #2;
      check_model();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_seg", seg, 7'h7F);
      chk("rst_an", an, 2'b11);
      chk("rst_dp", dp, 1'b1);
      chk("rst_wrap", wrap, 1'b0);
      chk("rst_alarm", alarm, 1'b0);
      @(posedge clk);
      #2;
      chk("rst_hold_seg", seg, 7'h7F);
      @(negedge clk);
      rst = 1'b0;
      t   = 0;
   endtask

   initial begin
      int         wraps;
      int         wrap_t;
      int         a_hi;
      int         a_first;
      int         a_last;
      int         dp_lo;
      int         r;
      logic [3:0] c;
      logic [3:0] pq[$];

      tbl[0]  = '{4'd0,  7'h40, 2'b11, 7'h7F};
      tbl[1]  = '{4'd1,  7'h79, 2'b11, 7'h7F};
      tbl[2]  = '{4'd2,  7'h24, 2'b11, 7'h7F};
      tbl[3]  = '{4'd3,  7'h30, 2'b11, 7'h7F};
      tbl[4]  = '{4'd4,  7'h19, 2'b11, 7'h7F};
      tbl[5]  = '{4'd5,  7'h12, 2'b11, 7'h7F};
      tbl[6]  = '{4'd6,  7'h02, 2'b11, 7'h7F};
      tbl[7]  = '{4'd7,  7'h78, 2'b11, 7'h7F};
      tbl[8]  = '{4'd8,  7'h00, 2'b11, 7'h7F};
      tbl[9]  = '{4'd9,  7'h10, 2'b11, 7'h7F};
      tbl[10] = '{4'd10, 7'h40, 2'b01, 7'h79};
      tbl[11] = '{4'd11, 7'h79, 2'b01, 7'h79};
      tbl[12] = '{4'd12, 7'h24, 2'b01, 7'h79};
      tbl[13] = '{4'd13, 7'h30, 2'b01, 7'h79};
      tbl[14] = '{4'd14, 7'h19, 2'b01, 7'h79};
      tbl[15] = '{4'd15, 7'h12, 2'b01, 7'h79};

      // Decode table: ones slot shows up after edge 2, tens slot after edge 5.
      for (int i = 0; i < 16; i++) begin
         do_reset();
         for (int k = 1; k <= 10; k++) begin
            step(tbl[i].cnt);
            if (t == 2) begin
               chk("tbl_ones_an", an, 2'b10);
               chk("tbl_ones_seg", seg, tbl[i].ones_seg);
            end
            if (t == 5) begin
               chk("tbl_tens_an", an, tbl[i].tens_an);
               chk("tbl_tens_seg", seg, tbl[i].tens_seg);
            end
         end
      end

      // Reset between edges while running, then display resumes.
      do_reset();
      for (int k = 0; k < 10; k++) step(4'd5);
      do_reset();
      step(4'd5);
      step(4'd5);
      chk("resume_an", an, 2'b10);
      chk("resume_seg", seg, 7'h12);

      // 2,1,0,0: no wrap.
      do_reset();
      wraps = 0;
      for (int k = 1; k <= 10; k++) begin
         c = (k == 1) ? 4'd2 : (k == 2) ? 4'd1 : 4'd0;
         step(c);
         if (wrap === 1'b1) wraps++;
      end
      chk("nowrap_count", wraps, 0);

      // 1,0,15,14 then hold: one wrap after edge 4, alarm edges 6..37.
      do_reset();
      wraps = 0; wrap_t = -1; a_hi = 0; a_first = -1; a_last = -1; dp_lo = 0;
      for (int k = 1; k <= 45; k++) begin
         c = (k == 1) ? 4'd1 : (k == 2) ? 4'd0 : (k == 3) ? 4'd15 : 4'd14;
         step(c);
         if (wrap === 1'b1) begin
            wraps++;
            if (wrap_t < 0) wrap_t = t;
         end
         if (alarm === 1'b1) begin
            a_hi++;
            a_last = t;
            if (a_first < 0) a_first = t;
         end
         if (dp === 1'b0) dp_lo++;
         if (t == 14) chk("off_an", an, 2'b11);
      end
      chk("wrap_count", wraps, 1);
      chk("wrap_edge", wrap_t, 4);
      chk("alarm_len", a_hi, ALARM_LEN);
      chk("alarm_first", a_first, 6);
      chk("alarm_last", a_last, 37);
      chk("dp_on_cycles", dp_lo, ALARM_LEN / 2);

      // Retrigger: second wrap after edge 26 (alarm cycle 20).
      do_reset();
      wraps = 0; a_hi = 0;
      for (int k = 1; k <= 64; k++) begin
         c = (k == 1) ? 4'd1 : (k == 2 || k == 24) ? 4'd0 : (k == 3 || k == 25) ? 4'd15 : 4'd14;
         step(c);
         if (wrap === 1'b1) wraps++;
         if (alarm === 1'b1) a_hi++;
         if (t == 28) chk("retrig_dp_on", dp, 1'b0);
         if (t == 36) chk("retrig_off_an", an, 2'b11);
         if (t == 44) chk("retrig_late_dp", dp, 1'b0);
         if (t == 59) chk("retrig_alarm_end", alarm, 1'b1);
         if (t == 60) chk("retrig_alarm_idle", alarm, 1'b0);
      end
      chk("retrig_wraps", wraps, 2);
      chk("retrig_alarm_len", a_hi, 54);

      // Randomized run with injected 0->15 and 0->0 pairs and a mid-run reset.
      do_reset();
      for (int k = 0; k < 700; k++) begin
         if (pq.size() == 0) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      pq = '{4'd0, 4'd15};
            else if (r == 1) pq = '{4'd0, 4'd0};
            else             pq.push_back(4'($urandom_range(0, 15)));
         end
         c = pq.pop_front();
         step(c);
         if (k == 350) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
